fetch_branch_ctrl: RTL
======================

Name: fetch_branch_ctrl

Overview:
- Parametrised stage-0 controller for the accumulator processor.
- Owns the PC, fetches instruction and operand bytes, and issues non-control instructions to stage 1 via a valid/ready handshake.
- Executes BRA/JMP/BSR/RTS/RTI/LMSK locally. Adds a return-address stack, a prioritised multi-line interrupt entry, and an outstanding-instruction counter so branches evaluate only on committed flags.

Parameters:
AW, 8, PC/address width
DW, 8, instruction/operand width (>= OPW+3, >= NUM_IRQ)
OPW, 5, opcode field width (instr[DW-1:DW-OPW])
NUM_IRQ, 4, interrupt request lines
RS_DEPTH, 4, return-stack entries (power of 2)
CNT_W, 3, outstanding-issue counter width
RESET_VEC, 0, PC after reset and after a stack-underflow fault
IRQ_VEC_BASE, 'hF0, vector for IRQ i = IRQ_VEC_BASE + i (mod 2^AW)

Ports:
clk in 1 system clock, rising edge
clr in 1 reset, asynchronous, active-low
mem_addr out AW read address
mem_rd out 1 read strobe; data valid on mem_rdata the next cycle
mem_rdata in DW memory read data
issue_valid out 1 instruction offered to stage 1
issue_ready in 1 stage 1 accepts
issue_instr out DW instruction being offered
ccr_valid in 1 one-cycle pulse: one issued instruction committed its flags
ccr_z in 1 zero flag, qualified by ccr_valid
ccr_v in 1 overflow flag, qualified by ccr_valid
irq_req in NUM_IRQ level interrupt requests
irq_mask out NUM_IRQ enable mask (1 = enabled)
irq_ack out NUM_IRQ one-hot, one-cycle acknowledge
in_isr out 1 servicing an interrupt
v_sticky out 1 overflow seen since reset/last RTI
stack_err out 1 sticky: push on full or pop on empty
pc out AW current PC
state out 4 FSM state code, for debug

Behaviour:
- Reset (clr low, asynchronous):
  - pc=RESET_VEC, state=IRQ_CHK, outstanding=0, stack empty.
  - All outputs 0: irq_mask=0, in_isr=0, v_sticky=0, stack_err=0, issue_valid=0, mem_rd=0.
  - Reset mid-handshake drops the offered instruction.
- IRQ_CHK: compute p = irq_req & irq_mask.
  - If p!=0 and !in_isr: lowest set index i wins; push pc; pc <= IRQ_VEC_BASE+i; irq_ack[i]=1 for this cycle; in_isr <= 1; go FETCH.
  - Otherwise go FETCH.
- FETCH: mem_rd=1, mem_addr=pc → DECODE.
- DECODE: ir <= mem_rdata; pc <= pc+1 (wraps mod 2^AW).
  - BRA, JMP, BSR, LMSK → OPND.
  - RTS, RTI → RET.
  - Any other opcode → ISSUE.
- OPND: read at pc; the next cycle opnd <= mem_rdata and pc+1.
  - BRA → BR_WAIT; JMP → TAKE; BSR → CALL; LMSK → MASK.
  - Takes 2 cycles.
- ISSUE: issue_valid=1, issue_instr=ir, held stable until issue_ready.
  - On handshake: outstanding+1 → IRQ_CHK.
  - If outstanding = 2^CNT_W-1, issue_valid is held 0 until a ccr_valid arrives.
- Counter: outstanding decrements on each ccr_valid.
  - Simultaneous issue handshake and ccr_valid leaves it unchanged.
  - ccr_valid when outstanding=0 is ignored.
  - v_sticky <= 1 on ccr_valid && ccr_v.
- BR_WAIT: stay while outstanding!=0. When 0, evaluate cond = ir[2:0] against the last latched ccr_z/ccr_v:
  - 000 BEQ z=1; 001 BNE z=0; 010 BVS v=1; 011 BVC v=0; 100 always.
  - 101–111 never taken (no-op).
  - Taken → TAKE; not taken → IRQ_CHK.
- TAKE: pc <= opnd[AW-1:0] → IRQ_CHK.
- CALL: push pc (return address, already past the operand) → TAKE.
- RET: pop into pc.
  - RTI additionally clears in_isr and v_sticky. If ccr_valid with ccr_v occurs the same cycle, the set wins.
  - Pop on empty: stack_err <= 1, pc <= RESET_VEC.
  - Then → IRQ_CHK.
- MASK: irq_mask <= opnd[NUM_IRQ-1:0] → IRQ_CHK. Takes effect at the next IRQ_CHK.
- Stack full:
  - A push when full sets stack_err and drops the push.
  - The target PC is still loaded.
- Nested interrupts are not taken while in_isr=1. Requests stay pending (level) until after RTI.

Decomposition:
- Package fbc_pkg holds:
  - Opcode constants: BRA 00110, JMP 00111, RTS 01000, RTI 01001, LMSK 01110, BSR 10101.
  - Condition codes 000–100.
  - State encodings: IRQ_CHK, FETCH, DECODE, OPND, ISSUE, BR_WAIT, TAKE, CALL, RET, MASK.
- One sub-module, ret_stack: parameters AW, RS_DEPTH; ports push, pop, din, dout, full, empty; synchronous, asynchronous active-low clear.

Test Plan:
- Reset, then ALU instruction at address 0 with issue_ready=0 for 3 cycles: issue_valid held 3 cycles with issue_instr stable; after handshake pc=1 and outstanding=1.
- BEQ target 'h40 with one outstanding issue: branch stalls in BR_WAIT until a ccr_valid pulse with z=1, then pc='h40. Repeat with z=0: pc = branch address+2.
- BSR 'h20 at 'h10, then RTS at 'h20: pc='h20, then pc='h12; stack empty afterwards, stack_err=0.
- LMSK 'b0110, then irq_req='b1110: irq_ack='b0010 for one cycle, pc='hF1, in_isr=1; a further request is ignored until RTI returns to the saved pc and clears in_isr.
- Five nested BSRs with RS_DEPTH=4: stack_err=1 after the fifth, fifth target still reached. RTS on an empty stack: pc=RESET_VEC.
- ccr_valid with v=1 → v_sticky=1; survives BSR/RTS; cleared by RTI. clr pulsed low mid-ISSUE: all outputs 0 asynchronously.

Source files
------------

// File: rtl/fbc_pkg.sv
// fbc_pkg: opcodes, branch condition codes and FSM states shared by the
// stage-0 fetch/branch controller.
package fbc_pkg;
    localparam logic [4:0] OP_BRA  = 5'b00110;
    localparam logic [4:0] OP_JMP  = 5'b00111;
    localparam logic [4:0] OP_RTS  = 5'b01000;
    localparam logic [4:0] OP_RTI  = 5'b01001;
    localparam logic [4:0] OP_LMSK = 5'b01110;
    localparam logic [4:0] OP_BSR  = 5'b10101;
    localparam logic [2:0] CC_BEQ  = 3'b000;
    localparam logic [2:0] CC_BNE  = 3'b001;
    localparam logic [2:0] CC_BVS  = 3'b010;
    localparam logic [2:0] CC_BVC  = 3'b011;
    localparam logic [2:0] CC_ALW  = 3'b100;
    typedef enum logic [3:0] {
        IRQ_CHK = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        OPND    = 4'd3,
        ISSUE   = 4'd4,
        BR_WAIT = 4'd5,
        TAKE    = 4'd6,
        CALL    = 4'd7,
        RET     = 4'd8,
        MASK    = 4'd9
    } state_t;
    // codes 101-111 fall through to "never taken"
    function automatic logic cond_met(input logic [2:0] cc, input logic z, input logic v);
        return cc == CC_BEQ ? z : cc == CC_BNE ? !z : cc == CC_BVS ? v : cc == CC_BVC ? !v : cc == CC_ALW;
    endfunction
endpackage

// File: rtl/fetch_branch_ctrl_ret_stack.sv
// ret_stack: LIFO of return addresses; pushes on full and pops on empty are
// ignored here and reported by the owner.
module ret_stack #(
    parameter int AW       = 8,
    parameter int RS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(RS_DEPTH);
    logic [AW-1:0] mem [RS_DEPTH];
    logic [PW:0]   cnt;
    assign full  = cnt == (PW+1)'(RS_DEPTH);
    assign empty = cnt == '0;
    assign dout  = mem[PW'(cnt - 1'b1)];
    always_ff @(posedge clk or negedge clr)
        if (!clr)
            cnt <= '0;
        else if (push && !full)
            cnt <= cnt + 1'b1;
        else if (pop && !empty)
            cnt <= cnt - 1'b1;
    always_ff @(posedge clk)
        if (push && !full)
            mem[PW'(cnt)] <= din;
endmodule

// File: rtl/fetch_branch_ctrl.sv
// fetch_branch_ctrl: stage-0 controller; fetches, issues ALU work to stage 1,
// and executes control-flow instructions and interrupt entry locally.
module fetch_branch_ctrl
    import fbc_pkg::*;
#(
    parameter int            AW           = 8,
    parameter int            DW           = 8,
    parameter int            OPW          = 5,
    parameter int            NUM_IRQ      = 4,
    parameter int            RS_DEPTH     = 4,
    parameter int            CNT_W        = 3,
    parameter logic [AW-1:0] RESET_VEC    = '0,
    parameter int            IRQ_VEC_BASE = 'hF0
) (
    input  logic               clk,
    input  logic               clr,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_rd,
    input  logic [DW-1:0]      mem_rdata,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [DW-1:0]      issue_instr,
    input  logic               ccr_valid,
    input  logic               ccr_z,
    input  logic               ccr_v,
    input  logic [NUM_IRQ-1:0] irq_req,
    output logic [NUM_IRQ-1:0] irq_mask,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               in_isr,
    output logic               v_sticky,
    output logic               stack_err,
    output logic [AW-1:0]      pc,
    output logic [3:0]         state
);
    state_t             st, st_n;
    logic [AW-1:0]      pc_n, rs_dout;
    logic [DW-1:0]      ir, ir_n, opnd, opnd_n;
    logic [OPW-1:0]     op, dop;
    logic [NUM_IRQ-1:0] mask_n, pend;
    logic [CNT_W-1:0]   outst, outst_n;
    logic               ph, ph_n, isr_n, vs_n, err_n, fz, fv;
    logic               take_irq, hs, dec, push, pop, full, empty;
    int                 idx;
    assign state       = st;
    assign mem_addr    = pc;
    assign mem_rd      = st == FETCH || (st == OPND && !ph);
    assign issue_valid = st == ISSUE && outst != '1;
    assign issue_instr = ir;
    assign hs          = issue_valid && issue_ready;
    assign dec         = ccr_valid && outst != '0;
    assign op          = ir[DW-1 -: OPW];
    assign dop         = mem_rdata[DW-1 -: OPW];
    assign pend        = irq_req & irq_mask;
    assign take_irq    = st == IRQ_CHK && |pend && !in_isr;
    assign irq_ack     = take_irq ? NUM_IRQ'(1) << idx : '0;
    assign push        = take_irq || st == CALL;
    assign pop         = st == RET;
    assign outst_n     = (hs && !dec) ? outst + 1'b1 : (dec && !hs) ? outst - 1'b1 : outst;
    always_comb begin
        idx = 0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[i]) idx = i;
    end
    ret_stack #(.AW(AW), .RS_DEPTH(RS_DEPTH)) u_stack (
        .clk   (clk),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (pc),
        .dout  (rs_dout),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        st_n   = st;
        pc_n   = pc;
        ir_n   = ir;
        opnd_n = opnd;
        ph_n   = ph;
        mask_n = irq_mask;
        isr_n  = in_isr;
        vs_n   = v_sticky | (ccr_valid & ccr_v);
        err_n  = stack_err | (push & full) | (pop & empty);
        case (st)
            IRQ_CHK: begin
                st_n = FETCH;
                if (take_irq) begin
                    pc_n  = AW'(IRQ_VEC_BASE + idx);
                    isr_n = 1'b1;
                end
            end
            FETCH: st_n = DECODE;
            DECODE: begin
                ir_n = mem_rdata;
                pc_n = pc + 1'b1;
                st_n = (dop == OP_BRA || dop == OP_JMP || dop == OP_BSR || dop == OP_LMSK) ? OPND :
                       (dop == OP_RTS || dop == OP_RTI) ? RET : ISSUE;
            end
            // phase 0 presents the read, phase 1 captures the operand byte
            OPND: begin
                ph_n = !ph;
                if (ph) begin
                    opnd_n = mem_rdata;
                    pc_n   = pc + 1'b1;
                    st_n   = op == OP_BRA ? BR_WAIT : op == OP_JMP ? TAKE : op == OP_BSR ? CALL : MASK;
                end
            end
            ISSUE: if (hs) st_n = IRQ_CHK;
            BR_WAIT: if (outst == '0) st_n = cond_met(ir[2:0], fz, fv) ? TAKE : IRQ_CHK;
            TAKE: begin
                pc_n = opnd[AW-1:0];
                st_n = IRQ_CHK;
            end
            CALL: st_n = TAKE;
            RET: begin
                pc_n = empty ? RESET_VEC : rs_dout;
                if (op == OP_RTI) begin
                    isr_n = 1'b0;
                    vs_n  = ccr_valid & ccr_v;
                end
                st_n = IRQ_CHK;
            end
            MASK: begin
                mask_n = opnd[NUM_IRQ-1:0];
                st_n   = IRQ_CHK;
            end
            default: st_n = IRQ_CHK;
        endcase
    end
    always_ff @(posedge clk or negedge clr)
        if (!clr)
            st <= IRQ_CHK;
        else
            st <= st_n;
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            pc        <= RESET_VEC;
            ir        <= '0;
            opnd      <= '0;
            ph        <= 1'b0;
            irq_mask  <= '0;
            in_isr    <= 1'b0;
            v_sticky  <= 1'b0;
            stack_err <= 1'b0;
            outst     <= '0;
            fz        <= 1'b0;
            fv        <= 1'b0;
        end else begin
            pc        <= pc_n;
            ir        <= ir_n;
            opnd      <= opnd_n;
            ph        <= ph_n;
            irq_mask  <= mask_n;
            in_isr    <= isr_n;
            v_sticky  <= vs_n;
            stack_err <= err_n;
            outst     <= outst_n;
            fz        <= ccr_valid ? ccr_z : fz;
            fv        <= ccr_valid ? ccr_v : fv;
        end
endmodule
